instr_fetch: RTL and testbench

//  Fetch stage of the jacaranda-8 core; sits directly upstream of the instruction decoder.

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_if.sv | 42 ++++
 rtl/instr_fetch_fifo.sv | 83 ++++++++
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module : instr_fetch_pkg
// Brief  : Shared jacaranda-8 fetch constants and sizing helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  localparam int              PC_W     = 8;
  localparam int              INSTR_W  = 8;
  localparam int              DEPTH    = 2;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  // Counter width able to hold the value n itself.
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module : instr_fetch_if
// Brief  : imem request/response, decoder handshake and execute redirect bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int PC_W_P    = instr_fetch_pkg::PC_W,
  parameter int INSTR_W_P = instr_fetch_pkg::INSTR_W
);

  logic                 imem_req;
  logic [PC_W_P-1:0]    imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [INSTR_W_P-1:0] imem_rdata;
  logic                 instr_valid;
  logic [INSTR_W_P-1:0] instr;
  logic [PC_W_P-1:0]    instr_pc;
  logic                 instr_ready;
  logic                 redirect_valid;
  logic [PC_W_P-1:0]    redirect_pc;
  logic                 halt;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
           redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
           redirect_valid, redirect_pc, halt
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
// ============================================================================
// Module : instr_fetch_fifo
// Brief  : In-order prefetch FIFO of {instr, pc}; flush beats push.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH_P = instr_fetch_pkg::DEPTH,
  parameter int DATA_W  = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push_i,
  input  logic [DATA_W-1:0]              push_data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic                           head_valid_o,
  output logic [DATA_W-1:0]              head_data_o,
  output logic [cnt_bits(DEPTH_P)-1:0]   count_o
);

  localparam int CNT_W = cnt_bits(DEPTH_P);
  localparam int IDX_W = idx_bits(DEPTH_P);

  logic [DATA_W-1:0] mem_q [DEPTH_P];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              w_push;
  logic              w_pop;

  assign head_valid_o = (count_q != '0);
  assign w_push       = push_i & ~flush_i;
  assign w_pop        = pop_i & head_valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = (wr_ptr_q == IDX_W'(DEPTH_P - 1)) ? '0 : wr_ptr_q + IDX_W'(1);
      if (w_pop)  rd_ptr_d = (rd_ptr_q == IDX_W'(DEPTH_P - 1)) ? '0 : rd_ptr_q + IDX_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Empty head reads as zero so the decoder never sees stale storage.
  assign head_data_o = head_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    !(w_push && !w_pop && (count_q == CNT_W'(DEPTH_P))));

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module : instr_fetch
// Brief  : jacaranda-8 fetch stage: PC, credit-limited imem reads, prefetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int              PC_W_P   = instr_fetch_pkg::PC_W,
  parameter int              DEPTH_P  = instr_fetch_pkg::DEPTH,
  parameter logic [PC_W_P-1:0] RESET_PC_P = instr_fetch_pkg::RESET_PC
) (
  input  logic          clock,
  input  logic          reset,
  instr_fetch_if.master bus
);

  localparam int CNT_W   = cnt_bits(DEPTH_P);
  localparam int IDX_W   = idx_bits(DEPTH_P);
  localparam int ENTRY_W = INSTR_W + PC_W_P;

  logic [PC_W_P-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   discard_q, discard_d;
  logic [PC_W_P-1:0]  aq_q [DEPTH_P];
  logic [IDX_W-1:0]   aq_wr_q, aq_rd_q;

  logic [CNT_W-1:0]   w_fifo_count;
  logic [CNT_W:0]     w_used;
  logic               w_req;
  logic               w_grant;
  logic               w_rsp;
  logic               w_push;
  logic               w_pop;
  logic               w_head_valid;
  logic [ENTRY_W-1:0] w_head_data;

  assign w_used  = {1'b0, w_fifo_count} + {1'b0, outstanding_q};
  assign w_req   = ~reset & ~bus.halt & ~bus.redirect_valid
                 & (w_used < (CNT_W + 1)'(DEPTH_P));
  assign w_grant = w_req & bus.imem_gnt;
  assign w_rsp   = bus.imem_rvalid;
  assign w_push  = w_rsp & ~bus.redirect_valid & (discard_q == '0);
  assign w_pop   = w_head_valid & bus.instr_ready;

  always_comb begin
    pc_d          = pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q;
    unique case ({w_grant, w_rsp})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    // Everything still in flight after a redirect belongs to the old path.
    if (bus.redirect_valid) begin
      pc_d      = bus.redirect_pc;
      discard_d = outstanding_d;
    end else begin
      if (w_grant) pc_d = pc_q + PC_W_P'(1);
      if (w_rsp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC_P;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Address queue tracks every request, stale or not, so it is never flushed.
  always_ff @(posedge clock) begin
    if (reset) begin
      aq_wr_q <= '0;
      aq_rd_q <= '0;
    end else begin
      if (w_grant) aq_wr_q <= (aq_wr_q == IDX_W'(DEPTH_P - 1)) ? '0 : aq_wr_q + IDX_W'(1);
      if (w_rsp)   aq_rd_q <= (aq_rd_q == IDX_W'(DEPTH_P - 1)) ? '0 : aq_rd_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_grant) aq_q[aq_wr_q] <= pc_q;
  end

  instr_fetch_fifo #(
    .DEPTH_P (DEPTH_P),
    .DATA_W  (ENTRY_W)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (w_push),
    .push_data_i ({bus.imem_rdata, aq_q[aq_rd_q]}),
    .pop_i       (w_pop),
    .flush_i     (bus.redirect_valid),
    .head_valid_o(w_head_valid),
    .head_data_o (w_head_data),
    .count_o     (w_fifo_count)
  );

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = w_head_valid;
  assign bus.instr       = w_head_data[ENTRY_W-1:PC_W_P];
  assign bus.instr_pc    = w_head_data[PC_W_P-1:0];

  a_rsp_expected : assert property (@(posedge clock) disable iff (reset)
    bus.imem_rvalid |-> (outstanding_q != '0));

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module : tb_instr_fetch
// Brief  : Directed self-checking bench for instr_fetch with a latency imem.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned lat     = 1;
  int unsigned cyc     = 0;

  typedef struct {
    int unsigned due;
    logic [7:0]  addr;
  } rsp_t;
  rsp_t rq[$];

  // imem model: in-order responses lat cycles after grant; data = addr ^ 8'h5A.
  initial begin
    rsp_t tmp;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        rq.delete();
      end else begin
        if (bus.imem_rvalid) tmp = rq.pop_front();
        if (bus.imem_req && bus.imem_gnt) rq.push_back('{due: cyc + lat, addr: bus.imem_addr});
      end
      #2;
      if (!reset && rq.size() > 0 && rq[0].due <= cyc + 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rq[0].addr ^ 8'h5A;
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 8'h00;
      end
    end
  end

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.instr_valid) break;
    end
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.halt           = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.imem_gnt = 1'b1; bus.instr_ready = 1'b1; bus.redirect_pc = 8'h00;
    do_reset();
    #1;
    n_tests++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b0, 8'h00, 1'b0, 8'h00, 8'h00}) begin
      n_fail++; $display("FAIL reset_outputs: got %h required %h",
        {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc}, {1'b0, 8'h00, 1'b0, 8'h00, 8'h00});
    end
  endtask

  task automatic test_stream();
    lat = 1; reset = 1'b0; #1;
    n_tests++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL stream_first_req: got %h required %h", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h00});
    end
    @(negedge clk);
    n_tests++;
    if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency: valid %b required 0", bus.instr_valid); end
    @(negedge clk);
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h00, 8'h5A}) begin
      n_fail++; $display("FAIL stream_w0: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h00, 8'h5A});
    end
    @(negedge clk);
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h01, 8'h5B}) begin
      n_fail++; $display("FAIL stream_w1: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h01, 8'h5B});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h02, 8'h58}) begin
      n_fail++; $display("FAIL stream_w2: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h02, 8'h58});
    end
  endtask

  task automatic test_backpressure();
    bus.instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.imem_req} !== {1'b1, 8'h02, 8'h58, 1'b0}) begin
      n_fail++; $display("FAIL bp_hold: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr, bus.imem_req}, {1'b1, 8'h02, 8'h58, 1'b0});
    end
    n_tests++;
    if ({dut.w_fifo_count, dut.outstanding_q} !== {2'd2, 2'd0}) begin
      n_fail++; $display("FAIL bp_count: got %h required %h", {dut.w_fifo_count, dut.outstanding_q}, {2'd2, 2'd0});
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h03, 8'h59}) begin
      n_fail++; $display("FAIL bp_drain1: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h03, 8'h59});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h04, 8'h5E}) begin
      n_fail++; $display("FAIL bp_drain2: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h04, 8'h5E});
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3; reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (dut.outstanding_q !== 2'd2) begin n_fail++; $display("FAIL redir_outstanding: got %0d required 2", dut.outstanding_q); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h40; #1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b required 0", bus.imem_req); end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_tests++;
    if ({bus.instr_valid, dut.discard_q, bus.imem_addr} !== {1'b0, 2'd2, 8'h40}) begin
      n_fail++; $display("FAIL redir_state: got %h required %h", {bus.instr_valid, dut.discard_q, bus.imem_addr}, {1'b0, 2'd2, 8'h40});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h40, 8'h1A}) begin
      n_fail++; $display("FAIL redir_first: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h40, 8'h1A});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h41, 8'h1B}) begin
      n_fail++; $display("FAIL redir_second: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h41, 8'h1B});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1; reset = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'hFE;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_tests++;
    if (bus.imem_addr !== 8'hFE) begin n_fail++; $display("FAIL wrap_addr: got %h required fe", bus.imem_addr); end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'hFE, 8'hA4}) begin
      n_fail++; $display("FAIL wrap_fe: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'hFE, 8'hA4});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'hFF, 8'hA5}) begin
      n_fail++; $display("FAIL wrap_ff: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'hFF, 8'hA5});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h00, 8'h5A}) begin
      n_fail++; $display("FAIL wrap_00: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h00, 8'h5A});
    end
  endtask

  task automatic test_gnt_stall();
    bus.imem_gnt = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 8'h02}) begin
        n_fail++; $display("FAIL stall_addr[%0d]: got %h required %h", i, {bus.imem_req, bus.imem_addr}, {1'b1, 8'h02});
      end
      @(negedge clk);
    end
    bus.imem_gnt = 1'b1;
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h02, 8'h58}) begin
      n_fail++; $display("FAIL stall_w02: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h02, 8'h58});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h03, 8'h59}) begin
      n_fail++; $display("FAIL stall_w03: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h03, 8'h59});
    end
  endtask

  task automatic test_halt();
    do_reset();
    lat = 2; reset = 1'b0;
    repeat (2) @(negedge clk);
    bus.halt = 1'b1; #1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_req: got %b required 0", bus.imem_req); end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h00, 8'h5A}) begin
      n_fail++; $display("FAIL halt_drain0: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h00, 8'h5A});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h01, 8'h5B}) begin
      n_fail++; $display("FAIL halt_drain1: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h01, 8'h5B});
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b0, 8'h02, 1'b0}) begin
      n_fail++; $display("FAIL halt_frozen: got %h required %h", {bus.imem_req, bus.imem_addr, bus.instr_valid}, {1'b0, 8'h02, 1'b0});
    end
    bus.halt = 1'b0;
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h02, 8'h58}) begin
      n_fail++; $display("FAIL halt_resume: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h02, 8'h58});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 3; reset = 1'b0;
    @(negedge clk);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 8'h80;
    @(negedge clk);
    n_tests++;
    if (dut.discard_q !== 2'd1) begin n_fail++; $display("FAIL b2b_discard1: got %0d required 1", dut.discard_q); end
    bus.redirect_pc = 8'h90;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    n_tests++;
    if ({dut.discard_q, bus.imem_addr} !== {2'd1, 8'h90}) begin
      n_fail++; $display("FAIL b2b_state: got %h required %h", {dut.discard_q, bus.imem_addr}, {2'd1, 8'h90});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h90, 8'hCA}) begin
      n_fail++; $display("FAIL b2b_first: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h90, 8'hCA});
    end
    wait_valid();
    n_tests++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 8'h91, 8'hCB}) begin
      n_fail++; $display("FAIL b2b_second: got %h required %h", {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 8'h91, 8'hCB});
    end
  endtask

  task automatic test_reset_midstream();
    bus.instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if ({bus.instr_valid, dut.w_fifo_count} !== {1'b1, 2'd2}) begin
      n_fail++; $display("FAIL mid_full: got %h required %h", {bus.instr_valid, dut.w_fifo_count}, {1'b1, 2'd2});
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, bus.imem_addr} !== {1'b0, 8'h00, 8'h00, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL mid_outputs: got %h required %h",
        {bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, bus.imem_addr}, {1'b0, 8'h00, 8'h00, 1'b0, 8'h00});
    end
    n_tests++;
    if ({dut.outstanding_q, dut.discard_q, dut.w_fifo_count} !== 6'd0) begin
      n_fail++; $display("FAIL mid_counters: got %h required 0", {dut.outstanding_q, dut.discard_q, dut.w_fifo_count});
    end
  endtask

  initial begin
    bus.imem_gnt       = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    bus.halt           = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_gnt_stall();
    test_halt();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
